// File: rtl/mult_stream_pkg.sv
// Shared types and widths for the streaming multiplier adapter and its core.
package mult_stream_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int unsigned BEAT_W    = 32;
    localparam int unsigned OP_W      = 64;
    localparam int unsigned PROD_W    = 128;
    localparam int unsigned BEATS_IN  = 4;
    localparam int unsigned BEATS_OUT = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned SET_W     = 4;

    // Select one 32-bit beat of the product, least significant first.
    function automatic logic [BEAT_W-1:0] beat_sel(input logic [PROD_W-1:0] p,
                                                   input logic [IDX_W-1:0]  idx);
        logic [BEAT_W-1:0] b;
        case (idx)
            2'd0:    b = p[BEAT_W-1:0];
            2'd1:    b = p[2*BEAT_W-1:BEAT_W];
            2'd2:    b = p[3*BEAT_W-1:2*BEAT_W];
            default: b = p[4*BEAT_W-1:3*BEAT_W];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mult.sv
// Combinational 64x64 unsigned multiplier, one-level Karatsuba on 32-bit halves.
module mult
    import mult_stream_pkg::*;
(
    input  logic [OP_W-1:0]   IN1,
    input  logic [OP_W-1:0]   IN2,
    output logic [PROD_W-1:0] OUTPUT
);

    localparam int unsigned H  = OP_W / 2;
    localparam int unsigned H2 = 2 * H;
    localparam int unsigned MW = 2 * H + 2;

    logic [H-1:0]  a_hi, a_lo, b_hi, b_lo;
    logic [H:0]    a_sum, b_sum;
    logic [H2-1:0] z_hi, z_lo;
    logic [MW-1:0] z_mid, z_cross;

    assign a_hi = IN1[OP_W-1:H];
    assign a_lo = IN1[H-1:0];
    assign b_hi = IN2[OP_W-1:H];
    assign b_lo = IN2[H-1:0];

    assign a_sum = (H+1)'(a_hi) + (H+1)'(a_lo);
    assign b_sum = (H+1)'(b_hi) + (H+1)'(b_lo);

    assign z_hi  = H2'(a_hi) * H2'(b_hi);
    assign z_lo  = H2'(a_lo) * H2'(b_lo);
    assign z_mid = MW'(a_sum) * MW'(b_sum);

    // Middle term a_hi*b_lo + a_lo*b_hi recovered from the sum product.
    assign z_cross = z_mid - MW'(z_hi) - MW'(z_lo);

    assign OUTPUT = {z_hi, z_lo} + (PROD_W'(z_cross) << H);

endmodule

// File: rtl/mult_stream_adapter.sv
// Stream wrapper around the combinational multiplier: loads 4 operand beats,
// holds them for a settle window, captures the product and emits 4 product beats.
module mult_stream_adapter
    import mult_stream_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [BEAT_W-1:0] S_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [BEAT_W-1:0] M_DATA,
    output logic              M_LAST,
    output logic              BUSY,
    output logic [CNT_W-1:0]  OP_COUNT
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("mult_stream_adapter: SETTLE_CYCLES must be within 1..15");
    end

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [SET_W-1:0]  cnt, cnt_n;
    logic [OP_W-1:0]   in1, in1_n, in2, in2_n;
    logic [PROD_W-1:0] prod, prod_n, core_out;
    logic              s_ready_n, m_valid_n, m_last_n, busy_n;
    logic [BEAT_W-1:0] m_data_n;
    logic [CNT_W-1:0]  op_count_n;
    logic              s_xfer, m_xfer;

    mult u_mult (
        .IN1    (in1),
        .IN2    (in2),
        .OUTPUT (core_out)
    );

    assign s_xfer = S_VALID & S_READY;
    assign m_xfer = M_VALID & M_READY;

    // Next-state and registered-output logic.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        in1_n      = in1;
        in2_n      = in2;
        prod_n     = prod;
        op_count_n = OP_COUNT;

        case (state)
            LOAD: begin
                if (s_xfer) begin
                    case (idx)
                        2'd0:    in1_n[BEAT_W-1:0]    = S_DATA;
                        2'd1:    in1_n[OP_W-1:BEAT_W] = S_DATA;
                        2'd2:    in2_n[BEAT_W-1:0]    = S_DATA;
                        default: in2_n[OP_W-1:BEAT_W] = S_DATA;
                    endcase
                    if (idx == IDX_W'(BEATS_IN - 1)) begin
                        state_n = SETTLE;
                        cnt_n   = SET_W'(SETTLE_CYCLES - 1);
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    prod_n  = core_out;
                    state_n = OUT;
                end else begin
                    cnt_n = cnt - SET_W'(1);
                end
            end
            OUT: begin
                if (m_xfer) begin
                    if (idx == IDX_W'(BEATS_OUT - 1)) begin
                        op_count_n = OP_COUNT + CNT_W'(1);
                        idx_n      = '0;
                        state_n    = LOAD;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = LOAD;
                idx_n   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        s_ready_n = (state_n == LOAD);
        m_valid_n = (state_n == OUT);
        m_last_n  = (state_n == OUT) && (idx_n == IDX_W'(BEATS_OUT - 1));
        m_data_n  = (state_n == OUT) ? beat_sel(prod_n, idx_n) : '0;
        busy_n    = !((state_n == LOAD) && (idx_n == '0));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= LOAD;
            idx      <= '0;
            cnt      <= '0;
            in1      <= '0;
            in2      <= '0;
            prod     <= '0;
            S_READY  <= 1'b0;
            M_VALID  <= 1'b0;
            M_LAST   <= 1'b0;
            M_DATA   <= '0;
            BUSY     <= 1'b0;
            OP_COUNT <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            in1      <= in1_n;
            in2      <= in2_n;
            prod     <= prod_n;
            S_READY  <= s_ready_n;
            M_VALID  <= m_valid_n;
            M_LAST   <= m_last_n;
            M_DATA   <= m_data_n;
            BUSY     <= busy_n;
            OP_COUNT <= op_count_n;
        end
    end

endmodule
